// File: rtl/ppm_tx_ctrl_pkg.sv
// Shared types and constants for the PPM frame sequencer.
// Optional preamble support is selected with the PPM_TX_PREAMBLE_EN macro.
package ppm_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_STROBE    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FLUSH     = 3'd5,
        ST_GAP       = 3'd6
    } state_e;

    localparam logic [1:0] PPM_SYNC_A = 2'b00;
    localparam logic [1:0] PPM_SYNC_B = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ppm_tx_timer.sv
// Loadable up-counter with an expire flag; shared by done-timeout and inter-frame-gap counting.
module ppm_tx_timer #(
    parameter int TW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] limit,
    output logic          expire
);

    logic [TW-1:0] count_r;

    // count register: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TW{1'b0}};
        end else if (clr) begin
            count_r <= {TW{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == limit);

endmodule

// File: rtl/ppm_tx_ctrl.sv
// Byte-to-symbol frame sequencer in front of the 2-bit PPM modulator.
// Define PPM_TX_PREAMBLE_EN to prepend PREAMBLE_LEN alternating sync symbols to every frame.
module ppm_tx_ctrl
    import ppm_tx_ctrl_pkg::*;
#(
    parameter int PREAMBLE_LEN = 4,
    parameter int IFG_CYCLES   = 16,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] ppm_code,
    output logic       ppm_strobe,
    input  logic       ppm_done,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout,
    output logic       underrun
);

    localparam int TW = $clog2(max_int(DONE_TIMEOUT, IFG_CYCLES) + 1);
    localparam logic [TW-1:0] TO_LIM  = TW'(DONE_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LIM = TW'(IFG_CYCLES - 1);

    state_e      state_r, state_s;
    logic [7:0]  sreg_r, sreg_s;
    logic [1:0]  sym_cnt_r, sym_cnt_s;
    logic        last_r, last_s;
    logic        load_first_r, load_first_s;
    logic [1:0]  ppm_code_r, ppm_code_s;
    logic        ppm_strobe_r, ppm_strobe_s;
    logic        s_ready_r, s_ready_s;
    logic        busy_r, busy_s;
    logic        frame_done_r, frame_done_s;
    logic        err_timeout_r, err_timeout_s;
    logic        underrun_r, underrun_s;
    logic        accept_s;
    logic        tmr_clr_s, tmr_en_s, tmr_exp_s;
    logic [TW-1:0] tmr_lim_s;

`ifdef PPM_TX_PREAMBLE_EN
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    logic [PW-1:0] pre_cnt_r, pre_cnt_s;
    logic          pre_wait_r, pre_wait_s;
`endif

    assign accept_s = s_valid & s_ready_r;

    ppm_tx_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_s),
        .en     (tmr_en_s),
        .limit  (tmr_lim_s),
        .expire (tmr_exp_s)
    );

    // next-state, datapath and next-output decode (outputs are registered from these)
    always_comb begin
        state_s       = state_r;
        sreg_s        = sreg_r;
        sym_cnt_s     = sym_cnt_r;
        last_s        = last_r;
        load_first_s  = 1'b0;
        frame_done_s  = 1'b0;
        err_timeout_s = 1'b0;
        underrun_s    = 1'b0;
        tmr_clr_s     = 1'b1;
        tmr_en_s      = 1'b0;
        tmr_lim_s     = (state_r == ST_GAP) ? GAP_LIM : TO_LIM;
`ifdef PPM_TX_PREAMBLE_EN
        pre_cnt_s     = pre_cnt_r;
        pre_wait_s    = pre_wait_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sreg_s    = s_data;
                    sym_cnt_s = 2'd0;
                    last_s    = s_last;
`ifdef PPM_TX_PREAMBLE_EN
                    state_s    = ST_PRE;
                    pre_cnt_s  = {PW{1'b0}};
                    pre_wait_s = 1'b0;
`else
                    state_s   = ST_STROBE;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef PPM_TX_PREAMBLE_EN
            ST_PRE: begin
                if (!pre_wait_r) begin
                    pre_wait_s = 1'b1;
                end else if (ppm_done) begin
                    if (pre_cnt_r == PW'(PREAMBLE_LEN - 1)) begin
                        state_s = ST_STROBE;
                    end else begin
                        pre_cnt_s  = pre_cnt_r + {{(PW-1){1'b0}}, 1'b1};
                        pre_wait_s = 1'b0;
                    end
                end else if (tmr_exp_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = last_r ? ST_GAP : ST_FLUSH;
                end else begin
                    tmr_clr_s = 1'b0;
                    tmr_en_s  = 1'b1;
                end
            end
`endif
            ST_STROBE: begin
                state_s = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // a done coinciding with expiry takes priority over the timeout
                if (ppm_done) begin
                    if (sym_cnt_r < 2'd3) begin
                        sreg_s    = {sreg_r[5:0], 2'b00};
                        sym_cnt_s = sym_cnt_r + 2'd1;
                        state_s   = ST_STROBE;
                    end else if (last_r) begin
                        frame_done_s = 1'b1;
                        state_s      = ST_GAP;
                    end else begin
                        load_first_s = 1'b1;
                        state_s      = ST_LOAD;
                    end
                end else if (tmr_exp_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = last_r ? ST_GAP : ST_FLUSH;
                end else begin
                    tmr_clr_s = 1'b0;
                    tmr_en_s  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    sreg_s    = s_data;
                    sym_cnt_s = 2'd0;
                    last_s    = s_last;
                    state_s   = ST_STROBE;
                end else if (load_first_r) begin
                    underrun_s = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (accept_s && s_last) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_GAP: begin
                if (tmr_exp_s) begin
                    state_s = ST_IDLE;
                end else begin
                    tmr_clr_s = 1'b0;
                    tmr_en_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        s_ready_s = (state_s == ST_IDLE) || (state_s == ST_LOAD) || (state_s == ST_FLUSH);
        busy_s    = (state_s != ST_IDLE);
`ifdef PPM_TX_PREAMBLE_EN
        ppm_strobe_s = (state_s == ST_STROBE) || ((state_s == ST_PRE) && !pre_wait_s);
        if (state_s == ST_STROBE) begin
            ppm_code_s = sreg_s[7:6];
        end else if ((state_s == ST_PRE) && !pre_wait_s) begin
            ppm_code_s = pre_cnt_s[0] ? PPM_SYNC_B : PPM_SYNC_A;
        end else if (state_s == ST_GAP) begin
            ppm_code_s = 2'b00;
        end else begin
            ppm_code_s = ppm_code_r;
        end
`else
        ppm_strobe_s = (state_s == ST_STROBE);
        if (state_s == ST_STROBE) begin
            ppm_code_s = sreg_s[7:6];
        end else if (state_s == ST_GAP) begin
            ppm_code_s = 2'b00;
        end else begin
            ppm_code_s = ppm_code_r;
        end
`endif
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            sreg_r        <= 8'h00;
            sym_cnt_r     <= 2'd0;
            last_r        <= 1'b0;
            load_first_r  <= 1'b0;
            ppm_code_r    <= 2'b00;
            ppm_strobe_r  <= 1'b0;
            s_ready_r     <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            underrun_r    <= 1'b0;
`ifdef PPM_TX_PREAMBLE_EN
            pre_cnt_r     <= {PW{1'b0}};
            pre_wait_r    <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            sreg_r        <= sreg_s;
            sym_cnt_r     <= sym_cnt_s;
            last_r        <= last_s;
            load_first_r  <= load_first_s;
            ppm_code_r    <= ppm_code_s;
            ppm_strobe_r  <= ppm_strobe_s;
            s_ready_r     <= s_ready_s;
            busy_r        <= busy_s;
            frame_done_r  <= frame_done_s;
            err_timeout_r <= err_timeout_s;
            underrun_r    <= underrun_s;
`ifdef PPM_TX_PREAMBLE_EN
            pre_cnt_r     <= pre_cnt_s;
            pre_wait_r    <= pre_wait_s;
`endif
        end
    end

    assign s_ready     = s_ready_r;
    assign ppm_code    = ppm_code_r;
    assign ppm_strobe  = ppm_strobe_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign err_timeout = err_timeout_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_ppm_tx_ctrl.sv
// Directed self-checking bench for ppm_tx_ctrl with a delayed-done modulator model.
module tb_ppm_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [1:0] ppm_code;
    logic       ppm_strobe;
    logic       ppm_done;
    logic       busy;
    logic       frame_done;
    logic       err_timeout;
    logic       underrun;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int codes[$];
    int scyc[$];
    int fd_cnt  = 0;
    int ur_cnt  = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int resp_delay = 10;
    bit resp_en = 1'b1;
    int dcnt = 0;

    int e_t1[8] = '{2, 3, 1, 0, 0, 0, 0, 0};
    int e_t2[8] = '{0, 3, 0, 3, 0, 0, 0, 0};
    int e_t3[8] = '{0, 1, 0, 2, 0, 3, 1, 0};
    int e_t5[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    int e_t6[8] = '{3, 3, 3, 3, 0, 0, 0, 0};

    ppm_tx_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .ppm_code    (ppm_code),
        .ppm_strobe  (ppm_strobe),
        .ppm_done    (ppm_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: log strobed codes and pulse outputs away from the active edge
    always @(negedge clk) begin
        if (ppm_strobe) begin
            codes.push_back(int'(ppm_code));
            scyc.push_back(cyc);
        end
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // modulator model: ppm_done pulse resp_delay cycles after each strobe
    initial begin
        ppm_done = 1'b0;
        forever begin
            @(negedge clk);
            ppm_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) ppm_done = 1'b1;
            end
            if (ppm_strobe && resp_en) dcnt = resp_delay;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_codes(input string tag, input int n, input int e[8]);
        check_val({tag, "_nstrobe"}, codes.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < codes.size()) check_val($sformatf("%s_code%0d", tag, i), codes[i], e[i]);
        end
    endtask

    task automatic clr_mon();
        codes.delete();
        scyc.delete();
        fd_cnt  = 0;
        ur_cnt  = 0;
        err_cnt = 0;
        err_cyc = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int acc);
        int k = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (!s_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) check_val("accept_wait", k, 0);
        acc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        while (codes.size() < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) check_val("strobe_wait", codes.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int acc;
        int n;
        int k;
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", int'(s_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_strobe", int'(ppm_strobe), 0);
        check_val("rst_code", int'(ppm_code), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_ready", int'(s_ready), 1);
        check_val("idle_busy", int'(busy), 0);

        // T1: single byte 0xB4, latency, gap length
        clr_mon();
        send_byte(8'hB4, 1'b1, acc);
        k = 0;
        while (!frame_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("t1_fd_seen", int'(frame_done), 1);
        n = 0;
        while (!s_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_val("t1_gap_len", n, 16);
        check_codes("t1", 4, e_t1);
        if (scyc.size() >= 2) begin
            check_val("t1_latency", scyc[0] - acc, 1);
            check_val("t1_sym_period", scyc[1] - scyc[0], 11);
        end
        check_val("t1_fd_cnt", fd_cnt, 1);
        check_val("t1_err", err_cnt, 0);
        check_val("t1_ur", ur_cnt, 0);

        // T3: two-byte frame with mid-frame stall
        clr_mon();
        send_byte(8'h12, 1'b0, acc);
        wait_strobes(4);
        repeat (40) @(negedge clk);
        check_val("t3_stall_nstrobe", codes.size(), 4);
        check_val("t3_underrun", ur_cnt, 1);
        send_byte(8'h34, 1'b1, acc);
        wait_idle("t3");
        check_codes("t3", 8, e_t3);
        check_val("t3_fd_cnt", fd_cnt, 1);
        check_val("t3_underrun_end", ur_cnt, 1);

        // T4: modulator stalls, timeout, rest of frame flushed
        clr_mon();
        resp_en = 1'b0;
        send_byte(8'hAA, 1'b0, acc);
        send_byte(8'h55, 1'b0, acc);
        send_byte(8'hC3, 1'b1, acc);
        wait_idle("t4");
        check_val("t4_err_cnt", err_cnt, 1);
        if (scyc.size() >= 1) check_val("t4_err_cycle", err_cyc - scyc[0], 1025);
        check_val("t4_nstrobe", codes.size(), 1);
        check_val("t4_fd_cnt", fd_cnt, 0);
        resp_en = 1'b1;

        // T5: done arrives in the expiry cycle
        clr_mon();
        resp_delay = 1024;
        send_byte(8'h1B, 1'b1, acc);
        wait_idle("t5");
        check_val("t5_err_cnt", err_cnt, 0);
        check_codes("t5", 4, e_t5);
        if (scyc.size() >= 2) check_val("t5_sym_period", scyc[1] - scyc[0], 1025);
        check_val("t5_fd_cnt", fd_cnt, 1);
        resp_delay = 10;

`ifdef PPM_TX_PREAMBLE_EN
        // T2: preamble before data
        clr_mon();
        send_byte(8'h00, 1'b1, acc);
        wait_idle("t2");
        check_codes("t2", 8, e_t2);
        check_val("t2_fd_cnt", fd_cnt, 1);
`endif

        // T6: reset in WAIT_DONE, then a fresh frame
        clr_mon();
        send_byte(8'h55, 1'b1, acc);
        wait_strobes(1);
        repeat (3) @(negedge clk);
        check_val("t6_pre_busy", int'(busy), 1);
        check_val("t6_pre_code", int'(ppm_code), 1);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", int'(busy), 0);
        check_val("t6_rst_ready", int'(s_ready), 0);
        check_val("t6_rst_strobe", int'(ppm_strobe), 0);
        check_val("t6_rst_code", int'(ppm_code), 0);
        check_val("t6_rst_fd", int'(frame_done), 0);
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        clr_mon();
        send_byte(8'hFF, 1'b1, acc);
        wait_idle("t6");
        check_codes("t6", 4, e_t6);
        check_val("t6_fd_cnt", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
